morse_blink_seq: RTL
====================

Name: morse_blink_seq

Overview:
- Parametrised Morse symbol sequencer; successor to the fixed 4-bit/3-bit-length blinker.
- Accepts one character per start handshake: code word plus symbol count.
- Plays the character out on an LED as timed marks and gaps: dot = 1 unit on, dash = DASH_UNITS units on, 1 unit off between symbols.
- Sits between the character encoder/ROM and the board LED driver; reports busy/done back to the character source.

Parameters:
- MAX_LEN, 4, maximum symbols per character; width of code input and upper bound of length.
- LEN_W, $clog2(MAX_LEN+1), width of length input.
- UNIT_CYCLES, 25000000, clock cycles per Morse time unit (0.5 s at 50 MHz); must be >= 1.
- DASH_UNITS, 3, dash mark length in units; must be >= 2.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to play the presented character; sampled only in IDLE.
- mcode  input  MAX_LEN  symbol bits, bit0 played first; 0 = dot, 1 = dash.
- mlength  input  LEN_W  number of symbols to play.
- abort  input  1  synchronous cancel of the character in progress.
- led  output  1  LED drive, 1 during a mark.
- shortbl  output  1  1 while the current mark is a dot.
- longbl  output  1  1 while the current mark is a dash.
- busy  output  1  1 from acceptance until the character completes or is aborted.
- finish  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async, rst_n=0): state IDLE; led, shortbl, longbl, busy, finish = 0; counters and latched code/length cleared. Reset mid-character discards it; no finish pulse.
- States: IDLE, MARK, GAP, TAIL (TAIL present only with the optional feature).
- IDLE:
  - start=1 latches mcode and len = min(mlength, MAX_LEN), then enters MARK on the next edge with busy=1.
  - If mlength = 0: no mark is played; finish pulses on the next cycle; busy stays 0.
- MARK:
  - led=1 for exactly UNIT_CYCLES cycles (dot) or DASH_UNITS*UNIT_CYCLES cycles (dash), selected by bit0 of the working code.
  - shortbl = led & ~bit; longbl = led & bit. Both are 0 outside MARK.
  - At end of mark: shift the working code right 1 and decrement the remaining count.
  - Remaining count > 0 -> GAP. Otherwise -> TAIL (feature on) or completion (feature off).
- GAP: led=0 for exactly UNIT_CYCLES cycles, then -> MARK.
- Completion:
  - Return to IDLE; finish=1 for exactly one cycle and busy=0 in that same cycle.
  - A start in the finish cycle is accepted.
- Unit counter:
  - Width $clog2(DASH_UNITS*UNIT_CYCLES+1); counts down to 1, reloads on each state entry.
  - Never wraps.
- start while busy: ignored, no effect on latched data.
- abort=1 in any non-IDLE state: next edge -> IDLE; led, shortbl, longbl, busy = 0; no finish.
- abort in IDLE: no effect. abort and start together in IDLE: abort wins, start is ignored.
- mcode bits above len: ignored.

Optional Feature:
- Macro: MORSE_LETTER_GAP_EN.
- Defined: after the last mark, enter TAIL with led=0 for (DASH_UNITS)*UNIT_CYCLES cycles and busy=1, then complete. Back-to-back characters therefore get a standard inter-letter gap.
- abort in TAIL behaves as in any other non-IDLE state.
- Undefined: TAIL state absent; completion occurs on the cycle immediately after the last mark ends.

Test Plan:
- UNIT_CYCLES=4, DASH_UNITS=3, MAX_LEN=4. Letter A (mcode=4'b0010, mlength=2), start pulse:
  - led = 1 for 4 cycles (shortbl=1), then 0 for 4, then 1 for 12 (longbl=1).
  - Then finish=1 for 1 cycle with busy=0; busy=1 throughout the 20 play cycles.
- Same stimulus with MORSE_LETTER_GAP_EN defined: after the 12-cycle dash, led=0 and busy=1 for 12 cycles, then a single finish pulse.
- mlength=0, start: no led activity, busy stays 0, finish pulses exactly once on the next cycle.
- mlength=7 with MAX_LEN=4, mcode=4'b1111: exactly 4 dashes (12 on / 4 off x3, 12 on) then finish; second start asserted mid-play is ignored.
- Letter O (mcode=4'b0111, mlength=3): abort asserted during the second dash -> next cycle led=0, busy=0, no finish; a new start afterwards plays normally.
- rst_n low for 1 cycle mid-GAP: all outputs 0 immediately (asynchronously), no finish pulse after release, IDLE accepts start on the next cycle.

Source files
------------

// File: rtl/morse_blink_seq.sv
// Morse symbol sequencer: plays one latched character as timed LED marks and gaps.
// Optional inter-letter tail gap enabled by defining MORSE_LETTER_GAP_EN.
module morse_blink_seq #(
  parameter int MAX_LEN     = 4,
  parameter int LEN_W       = $clog2(MAX_LEN+1),
  parameter int UNIT_CYCLES = 25000000,
  parameter int DASH_UNITS  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MAX_LEN-1:0] mcode,
  input  logic [LEN_W-1:0]   mlength,
  input  logic               abort,
  output logic               led,
  output logic               shortbl,
  output logic               longbl,
  output logic               busy,
  output logic               finish
);

  localparam int CNT_W = $clog2(DASH_UNITS*UNIT_CYCLES+1);
  localparam logic [CNT_W-1:0] UNIT_LD = CNT_W'(UNIT_CYCLES);
  localparam logic [CNT_W-1:0] DASH_LD = CNT_W'(DASH_UNITS*UNIT_CYCLES);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MARK = 2'd1,
    S_GAP  = 2'd2
`ifdef MORSE_LETTER_GAP_EN
    ,S_TAIL = 2'd3
`endif
  } state_t;

  state_t             r_state;
  logic [MAX_LEN-1:0] r_code;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_finish;

  state_t             w_state_nxt;
  logic [MAX_LEN-1:0] w_code_nxt;
  logic [LEN_W-1:0]   w_len_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_finish_nxt;
  logic [LEN_W-1:0]   w_len_clamp;
  logic [LEN_W-1:0]   w_len_dec;
  logic               w_cnt_done;

  assign w_len_clamp = (mlength > LEN_MAX) ? LEN_MAX : mlength;
  assign w_len_dec   = r_len - LEN_W'(1);
  assign w_cnt_done  = (r_cnt == CNT_W'(1));

  always_comb begin
    w_state_nxt  = r_state;
    w_code_nxt   = r_code;
    w_len_nxt    = r_len;
    w_cnt_nxt    = r_cnt;
    w_finish_nxt = 1'b0;
    led          = 1'b0;
    shortbl      = 1'b0;
    longbl       = 1'b0;
    busy         = 1'b1;
    finish       = r_finish;

    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start && !abort) begin
          w_code_nxt = mcode;
          w_len_nxt  = w_len_clamp;
          if (w_len_clamp == '0) begin
            w_finish_nxt = 1'b1;
          end else begin
            w_state_nxt = S_MARK;
            w_cnt_nxt   = mcode[0] ? DASH_LD : UNIT_LD;
          end
        end
      end
      S_MARK: begin
        led     = 1'b1;
        shortbl = ~r_code[0];
        longbl  = r_code[0];
        if (w_cnt_done) begin
          w_code_nxt = r_code >> 1;
          w_len_nxt  = w_len_dec;
          if (w_len_dec != '0) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = UNIT_LD;
          end else begin
`ifdef MORSE_LETTER_GAP_EN
            w_state_nxt = S_TAIL;
            w_cnt_nxt   = DASH_LD;
`else
            w_state_nxt  = S_IDLE;
            w_finish_nxt = 1'b1;
`endif
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        // code was already shifted at mark end, so bit0 selects the next mark length
        if (w_cnt_done) begin
          w_state_nxt = S_MARK;
          w_cnt_nxt   = r_code[0] ? DASH_LD : UNIT_LD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
`ifdef MORSE_LETTER_GAP_EN
      S_TAIL: begin
        if (w_cnt_done) begin
          w_state_nxt  = S_IDLE;
          w_finish_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt  = S_IDLE;
      w_finish_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_code   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_finish <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_code   <= w_code_nxt;
      r_len    <= w_len_nxt;
      r_cnt    <= w_cnt_nxt;
      r_finish <= w_finish_nxt;
    end
  end

endmodule
